// File: rtl/s_term_loopback_bist_if.sv
// Bus bundle between the south-terminal BIST and the vertical routing channels.
// start is a one-cycle request honoured only while idle; done is a one-cycle completion pulse.
interface s_term_loopback_bist_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [3:0]       N1BEG;
   logic [7:0]       N2BEG;
   logic [7:0]       N2BEGb;
   logic [15:0]      N4BEG;
   logic [3:0]       S1END;
   logic [7:0]       S2MID;
   logic [7:0]       S2END;
   logic [15:0]      S4END;
   logic             busy;
   logic             done;
   logic             pass;
   logic [35:0]      err_mask;
   logic [CNT_W-1:0] err_count;
   logic [2:0]       dbg_state;

   modport master (
      input  start, S1END, S2MID, S2END, S4END,
      output N1BEG, N2BEG, N2BEGb, N4BEG, busy, done, pass, err_mask, err_count, dbg_state
   );

   modport slave (
      output start, S1END, S2MID, S2END, S4END,
      input  N1BEG, N2BEG, N2BEGb, N4BEG, busy, done, pass, err_mask, err_count, dbg_state
   );
endinterface

// File: rtl/s_term_loopback_bist.sv
// Loopback BIST for the south end of the vertical single/double/quad channels.
// Optional walking-ones pre-phase enabled by defining S_TERM_BIST_WALK_EN.
module s_term_loopback_bist #(
   parameter int          NUM_VECTORS = 16,
   parameter int          SETTLE      = 2,
   parameter logic [35:0] SEED        = 36'h0_0000_0001,
   parameter int          CNT_W       = 8
) (
   input  logic                    UserCLK,
   input  logic                    reset,
   s_term_loopback_bist_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [35:0] SEED_EFF = (SEED == 36'd0) ? 36'd1 : SEED;
   localparam logic [7:0]  LAST_VEC = 8'(NUM_VECTORS - 1);
   localparam int          SW       = CNT_W + 6;

   state_t           state, state_next;
   logic [35:0]      lfsr;
   logic [35:0]      p_reg;
   logic [35:0]      cur_p;
   logic [35:0]      ret;
   logic [35:0]      mismatch;
   logic [5:0]       pop;
   logic [SW-1:0]    sum;
   logic [CNT_W-1:0] count_next;
   logic [3:0]       settle_cnt;
   logic [7:0]       vec_cnt;
   logic             in_walk;
   logic             run_end;
   logic             busy_r, done_r, pass_r;
   logic [35:0]      err_mask_r;
   logic [CNT_W-1:0] err_count_r;

`ifdef S_TERM_BIST_WALK_EN
   logic       walk_phase;
   logic [5:0] walk_idx;

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         walk_phase <= 1'b0;
         walk_idx   <= 6'd0;
      end else if (state == S_IDLE && bus.start) begin
         walk_phase <= 1'b1;
         walk_idx   <= 6'd0;
      end else if (state == S_CHECK && walk_phase) begin
         walk_idx <= walk_idx + 6'd1;
         if (walk_idx == 6'd35) walk_phase <= 1'b0;
      end
   end

   assign in_walk = walk_phase;
   assign cur_p   = walk_phase ? (36'd1 << walk_idx) : lfsr;
`else
   assign in_walk = 1'b0;
   assign cur_p   = lfsr;
`endif

   // Undo the north terminal's index reversal so mismatches line up with P bits.
   always_comb begin
      ret = '0;
      for (int i = 0; i < 4; i++) ret[i] = bus.S1END[3-i];
      for (int i = 0; i < 8; i++) begin
         ret[4+i]  = bus.S2MID[7-i];
         ret[12+i] = bus.S2END[7-i];
      end
      for (int i = 0; i < 16; i++) ret[20+i] = bus.S4END[15-i];
   end

   assign mismatch = p_reg ^ ret;

   always_comb begin
      pop = '0;
      for (int i = 0; i < 36; i++) pop = pop + {5'd0, mismatch[i]};
   end

   assign sum        = {6'd0, err_count_r} + {{CNT_W{1'b0}}, pop};
   assign count_next = (sum > {6'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   assign run_end    = (state == S_CHECK) && !in_walk && (vec_cnt == LAST_VEC);

   always_ff @(posedge UserCLK) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start) state_next = S_DRIVE;
         S_DRIVE: state_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
         S_WAIT:  if (settle_cnt <= 4'd1) state_next = S_CHECK;
         S_CHECK: state_next = run_end ? S_DONE : S_DRIVE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge UserCLK) begin
      if (reset) begin
         lfsr        <= SEED_EFF;
         p_reg       <= '0;
         settle_cnt  <= '0;
         vec_cnt     <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_mask_r  <= '0;
         err_count_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) begin
               lfsr        <= SEED_EFF;
               vec_cnt     <= '0;
               busy_r      <= 1'b1;
               pass_r      <= 1'b0;
               err_mask_r  <= '0;
               err_count_r <= '0;
            end
            S_DRIVE: begin
               p_reg      <= cur_p;
               settle_cnt <= 4'(SETTLE);
            end
            S_WAIT: settle_cnt <= settle_cnt - 4'd1;
            S_CHECK: begin
               err_mask_r  <= err_mask_r | mismatch;
               err_count_r <= count_next;
               if (!in_walk) begin
                  lfsr    <= {lfsr[34:0], lfsr[35] ^ lfsr[24]};
                  vec_cnt <= vec_cnt + 8'd1;
               end
               if (run_end) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  pass_r <= ((err_mask_r | mismatch) == 36'd0);
                  p_reg  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.N1BEG     = p_reg[3:0];
   assign bus.N2BEG     = p_reg[11:4];
   assign bus.N2BEGb    = p_reg[19:12];
   assign bus.N4BEG     = p_reg[35:20];
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.err_mask  = err_mask_r;
   assign bus.err_count = err_count_r;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_s_term_loopback_bist.sv
// Bench for s_term_loopback_bist: loopback model with fault injection, table of runs,
// scoreboard of per-run results, plus reset-abort and restart sequences.
module tb_s_term_loopback_bist;
`ifdef S_TERM_BIST_WALK_EN
   localparam int NV   = 1;
   localparam int ST   = 0;
   localparam int WALK = 36;
`else
   localparam int NV   = 8;
   localparam int ST   = 2;
   localparam int WALK = 0;
`endif
   localparam int          CNT_W   = 8;
   localparam logic [35:0] SEED_TB = 36'h8_1234_5679;
   localparam int          RUN_LEN = (WALK + NV) * (ST + 2);
   localparam int          MAXC    = (1 << CNT_W) - 1;
   localparam int          EW      = 36 + CNT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   fault_mode = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [EW-1:0] exp_q[$];

   logic [3:0]  s1;
   logic [7:0]  s2m, s2e;
   logic [15:0] s4;

   always #5 clk = ~clk;

   s_term_loopback_bist_if #(.CNT_W(CNT_W)) bif ();

   s_term_loopback_bist #(
      .NUM_VECTORS(NV), .SETTLE(ST), .SEED(SEED_TB), .CNT_W(CNT_W)
   ) dut (
      .UserCLK(clk),
      .reset  (rst),
      .bus    (bif.master)
   );

   // North-terminal U-turn with optional faults on the returning wires.
   always_comb begin
      for (int i = 0; i < 4; i++) s1[i] = bif.N1BEG[3-i];
      for (int i = 0; i < 8; i++) begin
         s2m[i] = bif.N2BEG[7-i];
         s2e[i] = bif.N2BEGb[7-i];
      end
      for (int i = 0; i < 16; i++) s4[i] = bif.N4BEG[15-i];
      case (fault_mode)
         1: s4[0] = 1'b0;
         2: begin s1 = ~s1; s2m = ~s2m; s2e = ~s2e; s4 = ~s4; end
         3: begin s1[1] = bif.N1BEG[1] | bif.N1BEG[2]; s1[2] = bif.N1BEG[1] | bif.N1BEG[2]; end
         default: ;
      endcase
   end

   assign bif.S1END = s1;
   assign bif.S2MID = s2m;
   assign bif.S2END = s2e;
   assign bif.S4END = s4;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected {err_mask, err_count} for one run, computed in P-index space.
   function automatic logic [EW-1:0] model(input int fault);
      logic [35:0] l, p, r, m, mask;
      int cnt;
      l = SEED_TB;
      mask = '0;
      cnt = 0;
      for (int v = 0; v < WALK + NV; v++) begin
         if (v < WALK) p = 36'd1 << v;
         else          p = l;
         r = p;
         case (fault)
            1: r[35] = 1'b0;
            2: r = ~p;
            3: begin r[1] = p[1] | p[2]; r[2] = p[1] | p[2]; end
            default: ;
         endcase
         m = p ^ r;
         mask |= m;
         cnt += $countones(m);
         if (v >= WALK) l = {l[34:0], l[35] ^ l[24]};
      end
      if (cnt > MAXC) cnt = MAXC;
      return {mask, CNT_W'(cnt)};
   endfunction

   function automatic logic [35:0] nbus();
      return {bif.N4BEG, bif.N2BEGb, bif.N2BEG, bif.N1BEG};
   endfunction

   task automatic run_one(input int fault, input bit glitch, input bit exp_pass);
      int n, busy_cnt, done_cnt, done_at;
      logic [EW-1:0] e;
      e = '0;
      fault_mode = fault;
      @(negedge clk);
      bif.start = 1'b1;
      exp_q.push_back(model(fault));
      @(negedge clk);
      bif.start = 1'b0;
      n = 1; busy_cnt = 0; done_cnt = 0; done_at = -1;
      while (n <= RUN_LEN + 10) begin
         if (bif.busy) busy_cnt++;
         if (bif.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("pass_at_done", 64'(bif.pass), 64'(exp_pass));
                  check("mask_at_done", 64'(bif.err_mask), 64'(e[EW-1:CNT_W]));
                  check("count_at_done", 64'(bif.err_count), 64'(e[CNT_W-1:0]));
               end
            end
         end
         bif.start = glitch && (n == 3 || n == 20);
         @(negedge clk);
         n++;
      end
      bif.start = 1'b0;
      if (done_at < 0 && exp_q.size() > 0) e = exp_q.pop_front();
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("done_latency", 64'(done_at), 64'(RUN_LEN + 1));
      check("busy_cycles", 64'(busy_cnt), 64'(RUN_LEN));
      // Results must hold in idle regardless of what the returning wires do.
      fault_mode = 2;
      repeat (3) @(negedge clk);
      check("pass_hold", 64'(bif.pass), 64'(exp_pass));
      check("mask_hold", 64'(bif.err_mask), 64'(e[EW-1:CNT_W]));
      check("count_hold", 64'(bif.err_count), 64'(e[CNT_W-1:0]));
      check("nbus_idle", 64'(nbus()), 64'd0);
      check("busy_idle", 64'(bif.busy), 64'd0);
   endtask

   typedef struct {
      int fault;
      bit glitch;
      bit exp_pass;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int n, done_cnt;
      tbl[0] = '{fault: 0, glitch: 1'b0, exp_pass: 1'b1};
      tbl[1] = '{fault: 1, glitch: 1'b0, exp_pass: 1'b0};
      tbl[2] = '{fault: 2, glitch: 1'b0, exp_pass: 1'b0};
      tbl[3] = '{fault: 3, glitch: 1'b0, exp_pass: 1'b0};
      tbl[4] = '{fault: 0, glitch: 1'b1, exp_pass: 1'b1};

      bif.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bif.busy), 64'd0);
      check("rst_done", 64'(bif.done), 64'd0);
      check("rst_pass", 64'(bif.pass), 64'd0);
      check("rst_mask", 64'(bif.err_mask), 64'd0);
      check("rst_count", 64'(bif.err_count), 64'd0);
      check("rst_nbus", 64'(nbus()), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_one(tbl[i].fault, tbl[i].glitch, tbl[i].exp_pass);

      // Abort a run with reset at cycle 10 while errors are accumulating.
      fault_mode = 2;
      @(negedge clk);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      n = 1;
      while (n < 10) begin
         @(negedge clk);
         n++;
      end
      check("pre_abort_count_nonzero", 64'(bif.err_count != '0), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(bif.busy), 64'd0);
      check("abort_nbus", 64'(nbus()), 64'd0);
      check("abort_count", 64'(bif.err_count), 64'd0);
      check("abort_done", 64'(bif.done), 64'd0);
      rst = 1'b0;
      done_cnt = 0;
      repeat (2 * RUN_LEN) begin
         @(negedge clk);
         if (bif.done) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);

      run_one(0, 1'b0, 1'b1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
